clken_sched: RTL and testbench
==============================

CLKEN_SCHED -- requirements
Module: clken_sched

Interface
REQ-001 The module SHALL have parameter PIX_DEFAULT, default 2'd0, giving the pixel-rate mode loaded at reset.
REQ-002 The module SHALL have parameter STEP_ENABLE, default 1'b1; when 0, STEP is ignored.
REQ-003 CLK_24M  in  1  sole clock; all state changes on its rising edge.
REQ-004 nRESET  in  1  reset; asynchronous assertion, active-low.
REQ-005 PAUSE_REQ  in  1  level request to freeze all clock enables.
REQ-006 STEP  in  1  single-cycle pulse; while paused, advances exactly one 1.5 MHz period.
REQ-007 PIX_MODE_REQ  in  2  requested pixel-rate mode.
REQ-008 CE_12M, CE_6M, CE_1_5M  out  1 each  single-cycle clock enables.
REQ-009 CE_PACLK  out  1  6 MHz enable, half a 6 MHz period after CE_6M.
REQ-010 CE_PIX  out  1  pixel enable selected by PIX_MODE.
REQ-011 CLK_A, CLK_B  out  1 each  PIX_MODE[0] and PIX_MODE[1] respectively.
REQ-012 PAUSE_ACK  out  1  high only in PAUSED.
REQ-013 STATE  out  2  RUN=0, DRAIN=1, PAUSED=2, STEP=3.

Function
REQ-014 A 4-bit phase counter CNT SHALL increment modulo 16 each cycle in RUN, DRAIN and STEP, and hold in PAUSED.
REQ-015 "Counting" SHALL mean STATE is RUN, DRAIN or STEP; all CE outputs SHALL be 0 when not counting.
REQ-016 While counting: CE_12M = (CNT[0]==1); CE_6M = (CNT[1:0]==3); CE_PACLK = (CNT[1:0]==1); CE_1_5M = (CNT==15).
REQ-017 CE outputs SHALL be combinational decodes of registered CNT and STATE, with zero latency relative to CNT.
REQ-018 CE_PIX SHALL equal CE_6M for mode 0, CE_12M for mode 1, (CNT[2:0]==7 while counting) for mode 2, and CE_1_5M for mode 3.
REQ-019 PIX_MODE SHALL load PIX_MODE_REQ only on a counting cycle with CNT==15, taking effect from the next cycle; otherwise it holds.
REQ-020 RUN: PAUSE_REQ=1 with CNT==15 SHALL go to PAUSED; PAUSE_REQ=1 with CNT!=15 SHALL go to DRAIN; otherwise stay RUN.
REQ-021 DRAIN: PAUSE_REQ=0 SHALL return to RUN (cancel); CNT==15 SHALL go to PAUSED; otherwise stay DRAIN.
REQ-022 Entry to PAUSED SHALL occur after a CNT==15 cycle, so CNT SHALL wrap to and hold 0 in PAUSED.
REQ-023 PAUSED: PAUSE_REQ=0 SHALL go to RUN; otherwise STEP=1 with STEP_ENABLE=1 SHALL go to STEP; otherwise stay PAUSED.
REQ-024 If PAUSE_REQ=0 and STEP=1 coincide in PAUSED, RUN SHALL win.
REQ-025 STEP: CNT==15 SHALL go to PAUSED if PAUSE_REQ=1, else RUN; STEP pulses during STEP SHALL be ignored.
REQ-026 Each STEP pulse SHALL therefore produce exactly 16 counting cycles: 8 CE_12M, 4 CE_6M, 4 CE_PACLK, 1 CE_1_5M.
REQ-027 PAUSE_ACK SHALL be registered state-equivalent: 1 in exactly the cycles where STATE==PAUSED.
REQ-028 No CE output SHALL ever be truncated or duplicated across a pause, resume or step boundary; the CE sequence with paused cycles removed SHALL match free-running operation.

Reset
REQ-029 nRESET low SHALL asynchronously force CNT=0, STATE=RUN and PIX_MODE=PIX_DEFAULT.
REQ-030 Consequently, during reset all CE outputs SHALL be 0, PAUSE_ACK=0, and {CLK_B,CLK_A}=PIX_DEFAULT.
REQ-031 Reset asserted mid-DRAIN or mid-STEP SHALL abandon the operation; after release, counting SHALL resume from CNT=0 in RUN.
REQ-032 The first cycle after release SHALL have CNT=0, with CE_12M first asserting on the second cycle.

Verification
REQ-033 Free run 64 cycles after reset -> 32 CE_12M, 16 CE_6M, 16 CE_PACLK, 4 CE_1_5M; CE_1_5M at CNT=15 only.
REQ-034 PAUSE_REQ=1 at CNT=5 -> DRAIN for cycles with CNT 6..15, PAUSED with PAUSE_ACK=1 on the next cycle, CNT=0, all CEs 0.
REQ-035 In PAUSED, pulse STEP -> exactly 16 counting cycles with 1 CE_1_5M, then PAUSED again with PAUSE_ACK=1.
REQ-036 In PAUSED, apply PAUSE_REQ=0 and STEP=1 together -> RUN next cycle; DRAIN with PAUSE_REQ dropped at CNT=9 -> RUN, no CE lost.
REQ-037 PIX_MODE_REQ=3 applied at CNT=4 -> CE_PIX follows mode 0 until the CNT=15 cycle, then matches CE_1_5M; CLK_A=CLK_B=1 from the next cycle.
REQ-038 nRESET pulsed low mid-STEP at CNT=7 -> immediate CNT=0, STATE=RUN and CEs 0; normal counting resumes after release.

Source files
------------

// File: rtl/clken_sched.sv
// Clock-enable scheduler: derives 12/6/1.5 MHz enables from a 24 MHz clock and
// supports pausing and single-stepping on 1.5 MHz period boundaries.
module clken_sched #(
  parameter logic [1:0] PIX_DEFAULT = 2'd0,
  parameter logic       STEP_ENABLE = 1'b1
) (
  input  logic       CLK_24M,
  input  logic       nRESET,
  input  logic       PAUSE_REQ,
  input  logic       STEP,
  input  logic [1:0] PIX_MODE_REQ,
  output logic       CE_12M,
  output logic       CE_6M,
  output logic       CE_1_5M,
  output logic       CE_PACLK,
  output logic       CE_PIX,
  output logic       CLK_A,
  output logic       CLK_B,
  output logic       PAUSE_ACK,
  output logic [1:0] STATE
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_PAUSED = 2'd2,
    ST_STEP   = 2'd3
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [1:0] pix_mode;
  logic       pause_ack;
  logic       counting;
  logic       cnt_last;
  logic       step_go;

  assign counting = (state != ST_PAUSED);
  assign cnt_last = (cnt == 4'd15);
  assign step_go  = STEP && STEP_ENABLE;

  // Phase counter, pixel-mode latch and pause/step state machine.
  // Pauses only ever begin after a CNT==15 cycle so no enable is cut short.
  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      cnt       <= 4'd0;
      state     <= ST_RUN;
      pix_mode  <= PIX_DEFAULT;
      pause_ack <= 1'b0;
    end else begin
      if (counting) begin
        cnt <= cnt + 4'd1;
      end else begin
        cnt <= cnt;
      end

      if (counting && cnt_last) begin
        pix_mode <= PIX_MODE_REQ;
      end else begin
        pix_mode <= pix_mode;
      end

      case (state)
        ST_RUN: begin
          if (PAUSE_REQ && cnt_last) begin
            state     <= ST_PAUSED;
            pause_ack <= 1'b1;
          end else if (PAUSE_REQ) begin
            state     <= ST_DRAIN;
            pause_ack <= 1'b0;
          end else begin
            state     <= ST_RUN;
            pause_ack <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (!PAUSE_REQ) begin
            state     <= ST_RUN;
            pause_ack <= 1'b0;
          end else if (cnt_last) begin
            state     <= ST_PAUSED;
            pause_ack <= 1'b1;
          end else begin
            state     <= ST_DRAIN;
            pause_ack <= 1'b0;
          end
        end
        ST_PAUSED: begin
          // Resume takes priority over a coincident step pulse.
          if (!PAUSE_REQ) begin
            state     <= ST_RUN;
            pause_ack <= 1'b0;
          end else if (step_go) begin
            state     <= ST_STEP;
            pause_ack <= 1'b0;
          end else begin
            state     <= ST_PAUSED;
            pause_ack <= 1'b1;
          end
        end
        ST_STEP: begin
          if (cnt_last && PAUSE_REQ) begin
            state     <= ST_PAUSED;
            pause_ack <= 1'b1;
          end else if (cnt_last) begin
            state     <= ST_RUN;
            pause_ack <= 1'b0;
          end else begin
            state     <= ST_STEP;
            pause_ack <= 1'b0;
          end
        end
        default: begin
          state     <= ST_RUN;
          pause_ack <= 1'b0;
        end
      endcase
    end
  end

  // Enable decode straight off the registered phase counter.
  always_comb begin
    CE_12M   = 1'b0;
    CE_6M    = 1'b0;
    CE_PACLK = 1'b0;
    CE_1_5M  = 1'b0;
    CE_PIX   = 1'b0;
    if (counting) begin
      CE_12M   = cnt[0];
      CE_6M    = (cnt[1:0] == 2'd3);
      CE_PACLK = (cnt[1:0] == 2'd1);
      CE_1_5M  = cnt_last;
      case (pix_mode)
        2'd0:    CE_PIX = (cnt[1:0] == 2'd3);
        2'd1:    CE_PIX = cnt[0];
        2'd2:    CE_PIX = (cnt[2:0] == 3'd7);
        2'd3:    CE_PIX = cnt_last;
        default: CE_PIX = 1'b0;
      endcase
    end else begin
      CE_12M   = 1'b0;
      CE_6M    = 1'b0;
      CE_PACLK = 1'b0;
      CE_1_5M  = 1'b0;
      CE_PIX   = 1'b0;
    end
  end

  assign CLK_A     = pix_mode[0];
  assign CLK_B     = pix_mode[1];
  assign PAUSE_ACK = pause_ack;
  assign STATE     = state;

endmodule

// File: tb/tb_clken_sched.sv
// Self-checking bench for clken_sched: a cycle model feeds a scoreboard queue,
// and directed checks cover pause, drain, step, pixel mode and reset.
module tb_clken_sched;

  logic       CLK_24M = 1'b0;
  logic       nRESET;
  logic       PAUSE_REQ;
  logic       STEP;
  logic [1:0] PIX_MODE_REQ;
  logic       CE_12M, CE_6M, CE_1_5M, CE_PACLK, CE_PIX;
  logic       CLK_A, CLK_B, PAUSE_ACK;
  logic [1:0] STATE;

  int checks   = 0;
  int failures = 0;
  int t12, t6, tpa, t15, tpix, tcount, nd;

  logic [3:0] m_cnt;
  logic [1:0] m_state;
  logic [1:0] m_mode;
  logic [9:0] sb_q[$];

  clken_sched #(.PIX_DEFAULT(2'd0), .STEP_ENABLE(1'b1)) dut (
    .CLK_24M(CLK_24M), .nRESET(nRESET), .PAUSE_REQ(PAUSE_REQ), .STEP(STEP),
    .PIX_MODE_REQ(PIX_MODE_REQ), .CE_12M(CE_12M), .CE_6M(CE_6M), .CE_1_5M(CE_1_5M),
    .CE_PACLK(CE_PACLK), .CE_PIX(CE_PIX), .CLK_A(CLK_A), .CLK_B(CLK_B),
    .PAUSE_ACK(PAUSE_ACK), .STATE(STATE)
  );

  always #5 CLK_24M = ~CLK_24M;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {CE_12M,CE_6M,CE_PACLK,CE_1_5M,CE_PIX,CLK_B,CLK_A,PAUSE_ACK,STATE}
  function automatic logic [9:0] expect_outs(input logic [3:0] c, input logic [1:0] s,
                                             input logic [1:0] m);
    logic on, e12, e6, epa, e15, epix;
    on   = (s != 2'd2);
    e12  = on && (c[0] == 1'b1);
    e6   = on && (c[1:0] == 2'd3);
    epa  = on && (c[1:0] == 2'd1);
    e15  = on && (c == 4'd15);
    case (m)
      2'd0:    epix = e6;
      2'd1:    epix = e12;
      2'd2:    epix = on && (c[2:0] == 3'd7);
      default: epix = e15;
    endcase
    return {e12, e6, epa, e15, epix, m[1], m[0], (s == 2'd2), s};
  endfunction

  function automatic logic [9:0] obs_vec();
    return {CE_12M, CE_6M, CE_PACLK, CE_1_5M, CE_PIX, CLK_B, CLK_A, PAUSE_ACK, STATE};
  endfunction

  task automatic zero_tally();
    t12 = 0; t6 = 0; tpa = 0; t15 = 0; tpix = 0; tcount = 0;
  endtask

  // Model of the coming rising edge, using the inputs as they stand now.
  task automatic model_advance();
    logic [1:0] ns;
    if (!nRESET) begin
      m_cnt = 4'd0; m_state = 2'd0; m_mode = 2'd0;
    end else begin
      ns = m_state;
      case (m_state)
        2'd0: if (PAUSE_REQ) ns = (m_cnt == 4'd15) ? 2'd2 : 2'd1;
        2'd1: if (!PAUSE_REQ) ns = 2'd0; else if (m_cnt == 4'd15) ns = 2'd2;
        2'd2: if (!PAUSE_REQ) ns = 2'd0; else if (STEP) ns = 2'd3;
        default: if (m_cnt == 4'd15) ns = PAUSE_REQ ? 2'd2 : 2'd0;
      endcase
      if (m_state != 2'd2) begin
        if (m_cnt == 4'd15) m_mode = PIX_MODE_REQ;
        m_cnt = m_cnt + 4'd1;
      end
      m_state = ns;
    end
  endtask

  task automatic cycle();
    logic [9:0] exp;
    model_advance();
    sb_q.push_back(expect_outs(m_cnt, m_state, m_mode));
    @(negedge CLK_24M);
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      exp = sb_q.pop_front();
      check("cycle_outputs", {22'd0, obs_vec()}, {22'd0, exp});
    end
    t12    += int'(CE_12M);
    t6     += int'(CE_6M);
    tpa    += int'(CE_PACLK);
    t15    += int'(CE_1_5M);
    tpix   += int'(CE_PIX);
    tcount += (STATE != 2'd2) ? 1 : 0;
  endtask

  initial begin
    nRESET = 1'b1; PAUSE_REQ = 1'b0; STEP = 1'b0; PIX_MODE_REQ = 2'd0;
    m_cnt = 4'd0; m_state = 2'd0; m_mode = 2'd0;
    #1 nRESET = 1'b0;
    #1;
    check("reset_async", {22'd0, obs_vec()}, 32'd0);
    repeat (3) cycle();

    // Release and free run
    nRESET = 1'b1;
    #1;
    check("release_cnt0", {22'd0, obs_vec()}, {22'd0, expect_outs(4'd0, 2'd0, 2'd0)});
    zero_tally();
    cycle();
    check("first_ce12", {31'd0, CE_12M}, 32'd1);
    repeat (63) cycle();
    check("free_ce12", t12, 32);
    check("free_ce6", t6, 16);
    check("free_paclk", tpa, 16);
    check("free_ce15", t15, 4);

    // Pause request at CNT=5 drains to the period boundary
    for (int i = 0; i < 20 && m_cnt != 4'd5; i++) cycle();
    PAUSE_REQ = 1'b1;
    cycle();
    check("drain_entry", {30'd0, STATE}, 32'd1);
    nd = 1;
    for (int i = 0; i < 20 && m_state == 2'd1; i++) begin
      cycle();
      if (STATE == 2'd1) nd++;
    end
    check("drain_len", nd, 10);
    check("paused_ack", {29'd0, PAUSE_ACK, STATE}, 32'b110);
    check("paused_ces", {27'd0, CE_12M, CE_6M, CE_PACLK, CE_1_5M, CE_PIX}, 32'd0);
    repeat (3) cycle();

    // Single step; a second STEP during the step is ignored
    zero_tally();
    STEP = 1'b1;
    cycle();
    STEP = 1'b0;
    check("step_entry", {30'd0, STATE}, 32'd3);
    for (int i = 0; i < 40 && m_state == 2'd3; i++) begin
      STEP = (i == 5);
      cycle();
    end
    STEP = 1'b0;
    check("step_cycles", tcount, 16);
    check("step_ce12", t12, 8);
    check("step_ce6", t6, 4);
    check("step_paclk", tpa, 4);
    check("step_ce15", t15, 1);
    check("step_reack", {31'd0, PAUSE_ACK}, 32'd1);
    repeat (2) cycle();

    // Resume beats a coincident step; drain cancelled at CNT=9
    PAUSE_REQ = 1'b0; STEP = 1'b1;
    cycle();
    STEP = 1'b0;
    check("resume_wins", {30'd0, STATE}, 32'd0);
    for (int i = 0; i < 20 && m_cnt != 4'd2; i++) cycle();
    PAUSE_REQ = 1'b1;
    cycle();
    for (int i = 0; i < 20 && m_cnt != 4'd9; i++) cycle();
    check("drain_at9", {30'd0, STATE}, 32'd1);
    PAUSE_REQ = 1'b0;
    cycle();
    check("drain_cancel", {30'd0, STATE}, 32'd0);
    zero_tally();
    repeat (16) cycle();
    check("cancel_ce12", t12, 8);
    check("cancel_ce15", t15, 1);

    // Pixel mode request at CNT=4 takes effect after the CNT=15 cycle
    for (int i = 0; i < 20 && m_cnt != 4'd4; i++) cycle();
    PIX_MODE_REQ = 2'd3;
    for (int i = 0; i < 20 && m_cnt != 4'd15; i++) cycle();
    check("mode_hold_clk", {30'd0, CLK_B, CLK_A}, 32'd0);
    check("mode_hold_pix", {31'd0, CE_PIX}, 32'd1);
    cycle();
    check("mode3_clk", {30'd0, CLK_B, CLK_A}, 32'd3);
    zero_tally();
    repeat (16) cycle();
    check("mode3_pix", tpix, 1);
    PIX_MODE_REQ = 2'd2;
    for (int i = 0; i < 20 && m_mode != 2'd2; i++) cycle();
    zero_tally();
    repeat (16) cycle();
    check("mode2_pix", tpix, 2);
    PIX_MODE_REQ = 2'd1;
    for (int i = 0; i < 20 && m_mode != 2'd1; i++) cycle();
    zero_tally();
    repeat (16) cycle();
    check("mode1_pix", tpix, 8);
    PIX_MODE_REQ = 2'd0;

    // Reset mid-step at CNT=7
    PAUSE_REQ = 1'b1;
    for (int i = 0; i < 40 && m_state != 2'd2; i++) cycle();
    STEP = 1'b1;
    cycle();
    STEP = 1'b0;
    for (int i = 0; i < 20 && m_cnt != 4'd7; i++) cycle();
    check("pre_reset_step", {30'd0, STATE}, 32'd3);
    #2 nRESET = 1'b0;
    #1;
    check("reset_mid_step", {22'd0, obs_vec()}, 32'd0);
    m_cnt = 4'd0; m_state = 2'd0; m_mode = 2'd0;
    PAUSE_REQ = 1'b0;
    repeat (2) cycle();
    nRESET = 1'b1;
    zero_tally();
    repeat (32) cycle();
    check("post_reset_ce12", t12, 16);
    check("post_reset_ce15", t15, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
